// File: rtl/fsmc_master.sv
// FSMC-style multiplexed AD bus initiator.
// One user request becomes one fully timed NE/NADV/NWE/NOE bus cycle.
module fsmc_master #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 16,
   parameter int ADDSET     = 2,
   parameter int ADDHLD     = 1,
   parameter int DATAST     = 4,
   parameter int BUSTURN    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   output logic                  ready,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   inout  wire  [ADDR_WIDTH-1:0] AD,
   output logic                  NE,
   output logic                  NADV,
   output logic                  NWE,
   output logic                  NOE
);

   localparam int CW = 16;
   localparam int AS = (ADDSET  < 1) ? 1 : ADDSET;
   localparam int AH = (ADDHLD  < 1) ? 1 : ADDHLD;
   localparam int DS = (DATAST  < 1) ? 1 : DATAST;
   localparam int BT = (BUSTURN < 1) ? 1 : BUSTURN;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_AHOLD = 3'd2,
      S_DATA  = 3'd3,
      S_TURN  = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  last;
   logic                  wr_q, wr_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
   logic                  ne_d, nadv_d, nwe_d, noe_d, oe_d;
   logic [ADDR_WIDTH-1:0] ad_d, ad_out;
   logic                  ad_oe;

   assign ready = (state == S_IDLE);
   assign last  = (cnt == '0);
   assign AD    = ad_oe ? ad_out : 'z;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = last ? '0 : cnt - 1'b1;
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      case (state)
         S_IDLE: if (req) begin
            state_nxt = S_ADDR;
            cnt_nxt   = CW'(AS - 1);
            wr_nxt    = wr;
            addr_nxt  = addr;
            wdata_nxt = wdata;
         end
         S_ADDR: if (last) begin
            state_nxt = S_AHOLD;
            cnt_nxt   = CW'(AH - 1);
         end
         S_AHOLD: if (last) begin
            state_nxt = S_DATA;
            cnt_nxt   = CW'(DS - 1);
         end
         S_DATA: if (last) begin
            state_nxt = S_TURN;
            cnt_nxt   = CW'(BT - 1);
         end
         S_TURN: if (last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so every pin is a flop.
   always_comb begin
      ne_d   = 1'b1;
      nadv_d = 1'b1;
      nwe_d  = 1'b1;
      noe_d  = 1'b1;
      oe_d   = 1'b0;
      ad_d   = addr_nxt;
      case (state_nxt)
         S_ADDR: begin
            ne_d   = 1'b0;
            nadv_d = 1'b0;
            oe_d   = 1'b1;
         end
         S_AHOLD: begin
            ne_d = 1'b0;
            oe_d = 1'b1;
         end
         S_DATA: begin
            ne_d = 1'b0;
            ad_d = ADDR_WIDTH'(wdata_nxt);
            if (wr_nxt) begin
               nwe_d = 1'b0;
               oe_d  = 1'b1;
            end else begin
               noe_d = 1'b0;
            end
         end
         S_TURN: begin
            ne_d = 1'b0;
            oe_d = wr_nxt;
            ad_d = ADDR_WIDTH'(wdata_nxt);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         NE      <= 1'b1;
         NADV    <= 1'b1;
         NWE     <= 1'b1;
         NOE     <= 1'b1;
         ad_oe   <= 1'b0;
         ad_out  <= '0;
         rdata   <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         wr_q    <= wr_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         NE      <= ne_d;
         NADV    <= nadv_d;
         NWE     <= nwe_d;
         NOE     <= noe_d;
         ad_oe   <= oe_d;
         ad_out  <= ad_d;
         done    <= (state == S_TURN) && last;
         if ((state == S_DATA) && last && !wr_q)
            rdata <= AD[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_fsmc_master.sv
// Randomised scoreboard bench for fsmc_master with a cycle-level bus model
// and a small behavioural responder on the AD bus.
module tb_fsmc_master;

   localparam int AS  = 2;
   localparam int AH  = 1;
   localparam int DS  = 4;
   localparam int BT  = 3;
   localparam int LAT = AS + AH + DS + BT + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0, wr = 1'b0;
   logic [17:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        ready, done;
   logic [15:0] rdata;
   logic        NE, NADV, NWE, NOE;
   wire  [17:0] AD;
   logic        tb_oe = 1'b0;
   logic [17:0] tb_val = '0;

   logic        req2 = 1'b0, wr2 = 1'b0;
   logic [17:0] addr2 = '0;
   logic [15:0] wdata2 = '0;
   logic        ready2, done2;
   logic [15:0] rdata2;
   logic        NE2, NADV2, NWE2, NOE2;
   wire  [17:0] AD2;

   assign AD = tb_oe ? tb_val : 'z;

   always #5 clk = ~clk;

   fsmc_master dut (
      .clk(clk), .reset(reset), .req(req), .ready(ready),
      .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
      .done(done), .AD(AD), .NE(NE), .NADV(NADV),
      .NWE(NWE), .NOE(NOE)
   );

   fsmc_master #(
      .ADDSET(0), .ADDHLD(0), .DATAST(1), .BUSTURN(0)
   ) dut2 (
      .clk(clk), .reset(reset), .req(req2), .ready(ready2),
      .wr(wr2), .addr(addr2), .wdata(wdata2), .rdata(rdata2),
      .done(done2), .AD(AD2), .NE(NE2), .NADV(NADV2),
      .NWE(NWE2), .NOE(NOE2)
   );

   typedef struct {
      bit          rd;
      logic [15:0] data;
   } exp_t;

   typedef struct packed {
      logic ne, nadv, nwe, noe, drv, dat;
   } pins_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] ref_mem[logic [17:0]];
   logic [15:0] resp_mem[logic [17:0]];
   logic [15:0] sb_last_rd = '0;
   logic [17:0] r_addr = '0;
   bit          acc_evt = 0;

   function automatic logic [15:0] dflt(input logic [17:0] a);
      return a[15:0] ^ 16'hC3C3;
   endfunction

   function automatic logic [15:0] resp_rd(input logic [17:0] a);
      return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] ref_rd(input logic [17:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // Expected pins k cycles after the accept edge (k=0: idle).
   function automatic pins_t model(input int k, input bit w);
      pins_t p = '{1, 1, 1, 1, 0, 0};
      if (k >= 1 && k <= AS) begin
         p.ne = 0; p.nadv = 0; p.drv = 1;
      end else if (k > AS && k <= AS + AH) begin
         p.ne = 0; p.drv = 1;
      end else if (k > AS + AH && k <= AS + AH + DS) begin
         p.ne = 0; p.dat = 1;
         if (w) begin p.nwe = 0; p.drv = 1; end
         else p.noe = 0;
      end else if (k > AS + AH + DS && k < LAT) begin
         p.ne = 0; p.dat = 1; p.drv = w;
      end
      return p;
   endfunction

   // Cycle monitor: pins, AD, done/rdata scoreboard, responder.
   initial begin : monitor
      int          k;
      bit          m_wr, acc_s, rst_s;
      logic [17:0] m_addr, exp_ad;
      logic [15:0] m_wdata;
      logic [5:0]  act_c, exp_c;
      pins_t       e;
      exp_t        x;
      k = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      @(posedge clk); #1;
      forever begin
         @(negedge clk);
         if (!NADV) r_addr = AD;
         if (!NWE) resp_mem[r_addr] = AD[15:0];
         e = model(k, m_wr);
         exp_ad = e.drv ? (e.dat ? {2'b00, m_wdata} : m_addr) : tb_val;
         act_c = {NE, NADV, NWE, NOE, ready, done};
         exp_c = {e.ne, e.nadv, e.nwe, e.noe,
                  (k == 0 || k == LAT), (k == LAT)};
         total++;
         if (act_c !== exp_c) begin
            bad++;
            $display("FAIL pins k=%0d got %b want %b (NE NADV NWE NOE rdy done)",
                     k, act_c, exp_c);
         end
         total++;
         if (AD !== exp_ad) begin
            bad++;
            $display("FAIL ad k=%0d got %h want %h", k, AD, exp_ad);
         end
         if (done === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL done unexpected got 1 want 0");
            end else begin
               x = sb.pop_front();
               if (rdata !== x.data) begin
                  bad++;
                  $display("FAIL rdata rd=%0d got %h want %h", x.rd, rdata, x.data);
               end
            end
         end
         rst_s = reset;
         acc_s = req && !reset && (k == 0 || k == LAT);
         if (acc_s) begin
            m_wr = wr; m_addr = addr; m_wdata = wdata;
         end
         @(posedge clk); #1;
         acc_evt = acc_s;
         if (rst_s) k = 0;
         else if (acc_s) k = 1;
         else if (k == LAT) k = 0;
         else if (k != 0) k++;
         e = model(k, m_wr);
         tb_oe = !e.drv;
         tb_val = !e.noe ? {2'b01, resp_rd(r_addr)} : 18'($urandom);
      end
   end

   task automatic push_exp(input bit w, input logic [17:0] a, input logic [15:0] d);
      exp_t x;
      if (w) begin
         ref_mem[a] = d;
         x.rd = 0; x.data = sb_last_rd;
      end else begin
         x.rd = 1; x.data = ref_rd(a);
         sb_last_rd = x.data;
      end
      sb.push_back(x);
   endtask

   task automatic issue(input bit w, input logic [17:0] a, input logic [15:0] d);
      int n = 0;
      req = 1; wr = w; addr = a; wdata = d;
      do begin
         @(posedge clk); #2; n++;
      end while (!acc_evt && n < 60);
      total++;
      if (!acc_evt) begin
         bad++;
         $display("FAIL accept timeout got none want accept a=%h", a);
      end else begin
         push_exp(w, a, d);
      end
      req = 0; wr = 1'($urandom); addr = 18'($urandom); wdata = 16'($urandom);
   endtask

   task automatic preload(input logic [17:0] a, input logic [15:0] d);
      ref_mem[a] = d;
      resp_mem[a] = d;
   endtask

   initial begin : stim
      logic [17:0] pool[6];
      logic [17:0] a;
      int          n, nadv_n, nwe_n, lat;
      pool = '{18'h10003, 18'h10001, 18'h00040, 18'h2F00F, 18'h3FFFE, 18'h00000};
      preload(18'h10001, 16'h1234);
      repeat (3) @(posedge clk);
      #2 reset = 0;

      issue(1, 18'h10003, 16'hA55A);
      issue(0, 18'h10001, 16'h0000);
      issue(0, 18'h10003, 16'h0000);

      // Reset landing in the DATA phase of a write.
      repeat (3) @(posedge clk);
      #2;
      issue(1, 18'h00040, 16'hBEEF);
      repeat (4) @(posedge clk);
      #2 reset = 1;
      sb.delete();
      repeat (3) @(posedge clk);
      #2 reset = 0;
      sb_last_rd = '0;
      @(negedge clk);
      total++;
      if (rdata !== 16'h0000) begin
         bad++;
         $display("FAIL reset rdata got %h want 0000", rdata);
      end
      @(posedge clk); #2;

      for (int i = 0; i < 40; i++) begin
         a = ($urandom % 4 == 0) ? 18'($urandom) : pool[$urandom % 6];
         issue(1'($urandom), a, 16'($urandom));
         if ($urandom % 3 == 0) begin
            repeat (3) begin @(posedge clk); #2; end
            req = 1; wr = 1'($urandom); addr = 18'h3FFFF; wdata = 16'($urandom);
            @(posedge clk); #2;
            req = 0;
         end
         repeat ($urandom_range(0, 10)) begin @(posedge clk); #2; end
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end

      // Clamped short timing on the second instance.
      @(posedge clk); #2;
      total++;
      if (ready2 !== 1'b1) begin
         bad++;
         $display("FAIL p2 ready got %b want 1", ready2);
      end
      req2 = 1; wr2 = 1; addr2 = 18'h2AAAA; wdata2 = 16'h1357;
      @(posedge clk); #2;
      req2 = 0;
      nadv_n = 0; nwe_n = 0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (!NADV2) begin
            nadv_n++;
            total++;
            if (AD2 !== 18'h2AAAA) begin
               bad++;
               $display("FAIL p2 addr got %h want 2aaaa", AD2);
            end
         end
         if (!NWE2) begin
            nwe_n++;
            total++;
            if (AD2 !== 18'h01357) begin
               bad++;
               $display("FAIL p2 wdata got %h want 01357", AD2);
            end
         end
         if (done2 === 1'b1 && lat == 0) lat = c;
         @(posedge clk);
      end
      total++;
      if (nadv_n != 1) begin
         bad++;
         $display("FAIL p2 nadv cycles got %0d want 1", nadv_n);
      end
      total++;
      if (nwe_n != 1) begin
         bad++;
         $display("FAIL p2 nwe cycles got %0d want 1", nwe_n);
      end
      total++;
      if (lat != 5) begin
         bad++;
         $display("FAIL p2 latency got %0d want 5", lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
